gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin arbiter and sequencer that shares one 32-bit `gcd` engine among `NREQ` requesters. It accepts operand pairs from requesters and grants one at a time. It launches the engine with a one-cycle start, waits for the engine's done pulse, and returns the result to the granted requester. It sits between the requester ports and the single engine instance, and drives the engine's `a_in`, `b_in` and `start` inputs.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `clk`  in  1: single clock; all logic updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: level request per requester, held until that requester's `ack`.
- `a_in`  in  32*NREQ: operand a; requester i uses bits [32*i +: 32].
- `b_in`  in  32*NREQ: operand b; same packing as `a_in`.
- `ack`  out  NREQ: one-hot, one-cycle pulse; operands of requester i captured.
- `rsp_valid`  out  NREQ: one-hot, one-cycle pulse; `rsp_result` is valid for requester i.
- `rsp_result`  out  32: GCD result; holds its value until the next response.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `eng_a`, `eng_b`  out  32: registered operands to the engine; stable from LAUNCH through WAIT.
- `eng_start`  out  1: engine start, high for exactly one cycle (LAUNCH).
- `eng_result`  in  32: engine result, sampled only when `eng_done` is high.
- `eng_done`  in  1: engine completion pulse.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESPOND.
- IDLE, no `req` bit set: stay in IDLE.
- IDLE, any `req` bit set:
  - Select the winner i as the first set bit searching upward from `ptr`, modulo NREQ.
  - Register `a_in[i]` and `b_in[i]` into `eng_a` and `eng_b`.
  - Register the grant index and go to LAUNCH.
- LAUNCH: `eng_start`=1 and `ack[i]`=1 for this one cycle; go to WAIT unconditionally.
- WAIT:
  - Hold until `eng_done`=1.
  - At that edge, load `rsp_result` from `eng_result` and go to RESPOND.
- RESPOND:
  - `rsp_valid[i]`=1 for one cycle.
  - `ptr` becomes (i+1) mod NREQ.
  - Return to IDLE.
- `req` is sampled only in IDLE, so a requester that holds `req` after `ack` issues a new operation.
- `eng_done` outside WAIT is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 other operations.
- Results are 32-bit, unsigned, and exact. gcd(x,0)=gcd(0,x)=x, and gcd(0,0)=0.
- Engine reset: the integrator ties the engine `reset_n` to `~reset`, so reset clears both blocks in the same cycle.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - FSM in IDLE, `ptr`=0.
  - `ack`, `rsp_valid`, `rsp_result`, `busy`, `eng_a`, `eng_b`, `eng_start` all 0.
- `reset` overrides every other input in the same edge, including mid-operation. The in-flight operation is dropped and no `rsp_valid` is issued for it.
- `req` sampled high at edge N in IDLE gives:
  - `ack` and `eng_start` high in cycle N+1;
  - WAIT from N+2.
- `eng_done` sampled high at edge M gives `rsp_valid` in cycle M+1 and IDLE at M+2.
- Arbiter overhead: 3 cycles per operation beyond the engine's run time. The earliest next grant decision is at edge M+2.
- `busy` rises in the cycle after the winning `req` is sampled. It falls in the cycle after RESPOND.
- Simultaneous `req` bits are resolved by round robin from `ptr` only. Lower index has no inherent priority.

## Configuration
- `GCD_ARB_ZERO_BYPASS_EN` defined:
  - In IDLE, if the winner's a==0 or b==0, skip LAUNCH and WAIT.
  - Load `rsp_result` with (a==0 ? b : a) and go directly to RESPOND.
  - `ack[i]` and `rsp_valid[i]` pulse together in that RESPOND cycle.
  - The engine is not started.
  - Latency is 1 cycle after the `req` sample.
- `GCD_ARB_ZERO_BYPASS_EN` undefined: zero operands go through the engine like any other pair. Results are identical; only latency differs.

## Test plan
- Single op: requester 0 sends a=48, b=18 -> `ack[0]` and `eng_start` together for one cycle; `rsp_valid[0]` one cycle after `eng_done`; `rsp_result`=6.
- Contention: requesters 1 and 2 both request in IDLE with `ptr`=0, (1: 1071,462) and (2: 270,192) -> requester 1 is served first with 21, then requester 2 with 6; `ptr`=3 afterwards.
- Fairness: NREQ=4, all `req` held high with a=b=7 -> grant order 0,1,2,3,0,1 and every `rsp_result`=7.
- Zero operands (a=0, b=35) -> `rsp_result`=35. With the macro: no `eng_start`, and `ack` and `rsp_valid` in the same cycle. Without it: normal LAUNCH/WAIT path, same result.
- Reset in WAIT: assert `reset` for one cycle while requester 3 is computing 100,75 -> all outputs 0 the next cycle; no `rsp_valid[3]`; a subsequent request from 3 returns 25.
- Stray done: pulse `eng_done` while in IDLE -> no state change and no `rsp_valid`.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one gcd engine among NREQ requesters.
// Optional zero-operand bypass enabled by defining GCD_ARB_ZERO_BYPASS_EN.
module gcd_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   a_in,
  input  logic [32*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 busy,
  output logic [31:0]          eng_a,
  output logic [31:0]          eng_b,
  output logic                 eng_start,
  input  logic [31:0]          eng_result,
  input  logic                 eng_done
);

`ifdef GCD_ARB_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic            r_bypass;
  logic [IW-1:0]   w_win;
  logic [IW:0]     w_sum;
  logic            w_found;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic            w_zero;
  logic            w_take_bypass;

  // First set request at or above r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == IW'(k)) begin
        w_a = a_in[32*k +: 32];
        w_b = b_in[32*k +: 32];
      end
    end
  end

  assign w_zero        = (w_a == '0) || (w_b == '0);
  assign w_take_bypass = ZERO_BYPASS && w_zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = w_take_bypass ? S_RESPOND : S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    if (eng_done) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // A bypassed grant acknowledges in RESPOND since LAUNCH never happens.
  always_comb begin
    ack       = '0;
    rsp_valid = '0;
    eng_start = 1'b0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_LAUNCH) begin
      eng_start    = 1'b1;
      ack[r_grant] = 1'b1;
    end
    if (r_state == S_RESPOND) begin
      rsp_valid[r_grant] = 1'b1;
      if (r_bypass) ack[r_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_bypass   <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      rsp_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_win;
            eng_a    <= w_a;
            eng_b    <= w_b;
            r_bypass <= w_take_bypass;
            if (w_take_bypass) rsp_result <= (w_a == '0) ? w_b : w_a;
          end
        end
        S_WAIT: begin
          if (eng_done) rsp_result <= eng_result;
        end
        S_RESPOND: begin
          r_ptr <= (r_grant == IW'(NREQ-1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: transaction-level reference model, emulated engine,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_gcd_arbiter;
  localparam int NREQ = 4;
`ifdef GCD_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [32*NREQ-1:0]  a_in = '0;
  logic [32*NREQ-1:0]  b_in = '0;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_result;
  logic                busy;
  logic [31:0]         eng_a;
  logic [31:0]         eng_b;
  logic                eng_start;
  logic [31:0]         eng_result = '0;
  logic                eng_done = 1'b0;

  always #5 clk = ~clk;

  gcd_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy),
    .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference model state: one transaction in flight at most
  bit              tx_act = 0, tx_fresh = 0, tx_closing = 0;
  int              tx_win = 0, m_ptr = 0;
  logic [31:0]     tx_gold = '0;
  logic [NREQ-1:0] e_ack = '0, e_rv = '0;
  logic            e_start = 1'b0, e_busy = 1'b0;
  logic [31:0]     e_res = '0, e_ea = '0, e_eb = '0;

  // bench-side bookkeeping
  int          tcount = 0, ack_tick = 0, rsp_tick = 0, done_tick = 0, start_cnt = 0;
  logic        start_at_ack = 1'b0;
  int          ack_q[$];
  int          rsp_idx_q[$];
  logic [31:0] rsp_res_q[$];
  bit          mode_random = 0, hold_all = 0, eng_pend = 0;
  int          eng_cnt = 0;
  int unsigned lat_lo = 1, lat_hi = 5;

  function automatic logic [31:0] gold_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got %0h expected %0h", nm, tcount, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic model_step();
    int w;
    logic [31:0] oa, ob;
    e_ack = '0;
    e_rv = '0;
    e_start = 1'b0;
    if (reset) begin
      tx_act = 0; tx_fresh = 0; tx_closing = 0; m_ptr = 0;
      e_res = '0; e_ea = '0; e_eb = '0;
    end else if (!tx_act) begin
      if (req != '0) begin
        w = rr_pick(req, m_ptr);
        oa = a_in[32*w +: 32];
        ob = b_in[32*w +: 32];
        e_ea = oa; e_eb = ob;
        tx_act = 1; tx_win = w; tx_gold = gold_gcd(oa, ob);
        e_ack[w] = 1'b1;
        if (BYP && (oa == 0 || ob == 0)) begin
          e_rv[w] = 1'b1;
          e_res = (oa == 0) ? ob : oa;
          m_ptr = (w + 1) % NREQ;
          tx_closing = 1;
        end else begin
          e_start = 1'b1;
          tx_fresh = 1;
        end
      end
    end else if (tx_closing) begin
      tx_act = 0; tx_closing = 0;
    end else if (tx_fresh) begin
      tx_fresh = 0;
    end else if (eng_done) begin
      e_rv[tx_win] = 1'b1;
      e_res = eng_result;
      m_ptr = (tx_win + 1) % NREQ;
      tx_closing = 1;
    end
    e_busy = tx_act;
  endtask

  task automatic new_op(input int i);
    logic [31:0] k, x, y;
    k = 32'($urandom_range(1, 500));
    x = k * 32'($urandom_range(0, 2000));
    y = k * 32'($urandom_range(0, 2000));
    case ($urandom_range(0, 7))
      0: x = '0;
      1: y = '0;
      2: begin x = $urandom; y = $urandom; end
      default: ;
    endcase
    a_in[32*i +: 32] = x;
    b_in[32*i +: 32] = y;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    a_in[32*i +: 32] = x;
    b_in[32*i +: 32] = y;
    req[i] = 1'b1;
  endtask

  // One cycle: model, compare all outputs, then requesters and engine react.
  task automatic tick();
    @(negedge clk);
    tcount++;
    model_step();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_result", rsp_result, e_res);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("eng_a", eng_a, e_ea);
    chk("eng_b", eng_b, e_eb);
    chk("eng_start", 32'(eng_start), 32'(e_start));
    if (e_rv != '0) chk("gcd_exact", rsp_result, tx_gold);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        ack_q.push_back(i);
        ack_tick = tcount;
        start_at_ack = eng_start;
        if (mode_random) begin
          if ($urandom_range(0, 1) == 1) new_op(i);
          else req[i] = 1'b0;
        end else if (!hold_all) req[i] = 1'b0;
      end
      if (rsp_valid[i]) begin
        rsp_idx_q.push_back(i);
        rsp_res_q.push_back(rsp_result);
        rsp_tick = tcount;
      end
    end
    if (eng_start) start_cnt++;
    if (eng_done) eng_done = 1'b0;
    if (reset) eng_pend = 0;
    else if (eng_start) begin
      eng_pend = 1;
      eng_cnt = int'($urandom_range(lat_lo, lat_hi));
    end else if (eng_pend) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_pend = 0;
        eng_done = 1'b1;
        eng_result = gold_gcd(eng_a, eng_b);
        done_tick = tcount;
      end
    end else if (mode_random && $urandom_range(0, 15) == 0) begin
      eng_done = 1'b1;
      eng_result = $urandom;
    end
    if (mode_random) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          new_op(i);
          req[i] = 1'b1;
        end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
    end
  endtask

  task automatic clear_logs();
    ack_q.delete();
    rsp_idx_q.delete();
    rsp_res_q.delete();
  endtask

  task automatic wait_acks(input int n, input int limit);
    int t = 0;
    while (ack_q.size() < n && t < limit) begin tick(); t++; end
    chk("ack_wait", 32'(ack_q.size()), 32'(n));
  endtask

  task automatic wait_rsps(input int n, input int limit);
    int t = 0;
    while (rsp_idx_q.size() < n && t < limit) begin tick(); t++; end
    chk("rsp_wait", 32'(rsp_idx_q.size()), 32'(n));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"}, 32'(ack), 32'd0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_rsp_result"}, rsp_result, 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_eng_a"}, eng_a, 32'd0);
    chk({nm, "_eng_b"}, eng_b, 32'd0);
    chk({nm, "_eng_start"}, 32'(eng_start), 32'd0);
  endtask

  initial begin
    int s0;
    int t;
    tick();
    tick();
    chk_all_zero("reset_state");
    reset = 1'b0;

    // single operation
    clear_logs();
    set_op(0, 48, 18);
    wait_acks(1, 20);
    chk("single_ack_idx", 32'(ack_q[0]), 32'd0);
    chk("single_start_with_ack", 32'(start_at_ack), 32'd1);
    wait_rsps(1, 50);
    chk("single_idx", 32'(rsp_idx_q[0]), 32'd0);
    chk("single_result", rsp_res_q[0], 32'd6);
    chk("single_done_to_rsp", 32'(rsp_tick - done_tick), 32'd1);

    // contention from ptr=0, then a follow-up proving ptr moved to 3
    pulse_reset();
    clear_logs();
    set_op(1, 1071, 462);
    set_op(2, 270, 192);
    wait_rsps(2, 100);
    chk("cont_first_idx", 32'(rsp_idx_q[0]), 32'd1);
    chk("cont_first_res", rsp_res_q[0], 32'd21);
    chk("cont_second_idx", 32'(rsp_idx_q[1]), 32'd2);
    chk("cont_second_res", rsp_res_q[1], 32'd6);
    clear_logs();
    set_op(0, 9, 6);
    set_op(3, 14, 21);
    wait_rsps(2, 100);
    chk("ptr3_first_idx", 32'(rsp_idx_q[0]), 32'd3);
    chk("ptr3_first_res", rsp_res_q[0], 32'd7);
    chk("ptr3_second_idx", 32'(rsp_idx_q[1]), 32'd0);
    chk("ptr3_second_res", rsp_res_q[1], 32'd3);

    // fairness with every requester holding req
    pulse_reset();
    clear_logs();
    hold_all = 1;
    for (int i = 0; i < NREQ; i++) set_op(i, 7, 7);
    wait_rsps(6, 200);
    req = '0;
    hold_all = 0;
    for (int k = 0; k < 6; k++) begin
      chk("fair_order", 32'(rsp_idx_q[k]), 32'(k % NREQ));
      chk("fair_result", rsp_res_q[k], 32'd7);
    end

    // zero operand
    tick();
    tick();
    clear_logs();
    s0 = start_cnt;
    set_op(0, 0, 35);
    wait_rsps(1, 50);
    chk("zero_result", rsp_res_q[0], 32'd35);
    chk("zero_starts", 32'(start_cnt - s0), BYP ? 32'd0 : 32'd1);
    chk("zero_ack_rsp_same", 32'(ack_tick == rsp_tick), BYP ? 32'd1 : 32'd0);

    // reset while requester 3 waits on the engine
    tick();
    clear_logs();
    lat_lo = 8;
    lat_hi = 8;
    set_op(3, 100, 75);
    wait_acks(1, 20);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("wait_reset");
    reset = 1'b0;
    clear_logs();
    repeat (15) tick();
    chk("wait_reset_no_rsp", 32'(rsp_idx_q.size()), 32'd0);
    lat_lo = 1;
    lat_hi = 5;
    set_op(3, 100, 75);
    wait_rsps(1, 50);
    chk("after_reset_idx", 32'(rsp_idx_q[0]), 32'd3);
    chk("after_reset_res", rsp_res_q[0], 32'd25);

    // stray engine done while idle
    tick();
    tick();
    clear_logs();
    eng_done = 1'b1;
    eng_result = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_no_rsp", 32'(rsp_idx_q.size()), 32'd0);
    chk("stray_result_held", rsp_result, 32'd25);

    // randomized traffic
    mode_random = 1;
    repeat (4000) tick();
    mode_random = 0;
    reset = 1'b0;
    req = '0;
    t = 0;
    while (busy && t < 100) begin tick(); t++; end
    tick();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
